// File: rtl/ct_spsram_param.sv
// ----------------------------------------------------------------------------
// ct_spsram_param
//   Parametrised single-port synchronous SRAM used for the C910 cache and
//   buffer arrays. It provides per-lane active-low write masking, an optional
//   output register stage (PIPE), a read-valid strobe, and an optional clear
//   engine that zeroes the whole array after reset.
//
//   Optional feature macro: CT_SPSRAM_INIT_CLR_EN
//     defined   : after reset release the clear FSM (CLR -> RDY) writes zero
//                 to every entry, one entry per cycle. INIT_DONE rises on the
//                 edge that writes the last entry.
//     undefined : there is no FSM and no counter. INIT_DONE rises on the first
//                 edge after reset release. Array contents are undefined until
//                 they are written.
//
// Parameters
//   ADDR_WIDTH  address bits; depth = 2**ADDR_WIDTH
//   DATA_WIDTH  bits per entry
//   WE_WIDTH    write-mask lanes; DATA_WIDTH must be a multiple of WE_WIDTH
//   PIPE        extra output register stages (0 or 1)
//
// Ports
//   CLK        clock; all state updates on the rising edge
//   cpurst_b   asynchronous reset, active low
//   CEN        chip enable, active low
//   GWEN       global write enable, active low (0 = write, 1 = read)
//   WEN        per-lane write enable, active low
//   A / D      address / write data
//   Q          read data; holds its last read value
//   Q_VLD      one-cycle strobe that marks new read data on Q
//   INIT_DONE  array is ready and accesses are accepted
// ----------------------------------------------------------------------------
`timescale 1ns/1ps

// One write-mask lane. It owns an LW-bit slice of every entry. The storage
// has no reset.
module ct_spsram_param_lane #(
  parameter int AW = 10,
  parameter int LW = 1
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [LW-1:0] wdata_i,
  output logic [LW-1:0] rdata_o
);
  logic [LW-1:0] mem_q [2**AW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Asynchronous array read. The parent module registers this value, so the
  // macro still behaves as a synchronous-read SRAM.
  assign rdata_o = mem_q[addr_i];
endmodule

module ct_spsram_param #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 128,
  parameter int WE_WIDTH   = 128,
  parameter int PIPE       = 0
) (
  input  logic                  CLK,
  input  logic                  cpurst_b,
  input  logic                  CEN,
  input  logic                  GWEN,
  input  logic [WE_WIDTH-1:0]   WEN,
  input  logic [ADDR_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] D,
  output logic [DATA_WIDTH-1:0] Q,
  output logic                  Q_VLD,
  output logic                  INIT_DONE
);
  localparam int LW = DATA_WIDTH / WE_WIDTH;

  logic                  init_done_q;
  logic                  acc, rd_acc, wr_acc;
  logic                  clr_act;
  logic [ADDR_WIDTH-1:0] clr_addr;

  // Accesses are accepted only after the array is ready. Before that, all
  // request inputs are ignored.
  assign acc    = ~CEN & init_done_q;
  assign rd_acc = acc &  GWEN;
  assign wr_acc = acc & ~GWEN;

`ifdef CT_SPSRAM_INIT_CLR_EN
  typedef enum logic {ST_CLR, ST_RDY} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;

  // The clear engine writes one entry per cycle. INIT_DONE is registered
  // together with the transition to RDY, so it rises on the same edge that
  // writes the last entry.
  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q     <= ST_CLR;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_CLR: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
            state_q     <= ST_RDY;
            init_done_q <= 1'b1;
          end
        end
        default: init_done_q <= 1'b1;
      endcase
    end
  end

  assign clr_act  = (state_q == ST_CLR);
  assign clr_addr = cnt_q;
`else
  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) init_done_q <= 1'b0;
    else           init_done_q <= 1'b1;
  end

  assign clr_act  = 1'b0;
  assign clr_addr = '0;
`endif

  assign INIT_DONE = init_done_q;

  // Single array port. The clear engine owns the port while it runs. User
  // accesses cannot collide with it because acc is gated by INIT_DONE.
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] port_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [WE_WIDTH-1:0]   wr_lane;
  logic [WE_WIDTH-1:0]   lane_we;
  logic [DATA_WIDTH-1:0] rd_data;

  always_comb begin
    wr_en     = wr_acc;
    port_addr = A;
    wr_data   = D;
    wr_lane   = ~WEN;
    if (clr_act) begin
      wr_en     = 1'b1;
      port_addr = clr_addr;
      wr_data   = '0;
      wr_lane   = '1;
    end
  end

  assign lane_we = {WE_WIDTH{wr_en}} & wr_lane;

  for (genvar g = 0; g < WE_WIDTH; g++) begin : g_lane
    ct_spsram_param_lane #(.AW(ADDR_WIDTH), .LW(LW)) u_lane (
      .clk_i   (CLK),
      .we_i    (lane_we[g]),
      .addr_i  (port_addr),
      .wdata_i (wr_data[g*LW +: LW]),
      .rdata_o (rd_data[g*LW +: LW])
    );
  end

  // Read stage 1: capture only on an accepted read, so Q holds its value
  // through writes, idle cycles and rejected accesses.
  logic [DATA_WIDTH-1:0] rd_q;
  logic                  rd_vld_q;

  always_ff @(posedge CLK or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) rd_q <= rd_data;
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic [DATA_WIDTH-1:0] out_q;
    logic                  out_vld_q;

    always_ff @(posedge CLK or negedge cpurst_b) begin
      if (!cpurst_b) begin
        out_q     <= '0;
        out_vld_q <= 1'b0;
      end else begin
        out_vld_q <= rd_vld_q;
        if (rd_vld_q) out_q <= rd_q;
      end
    end

    assign Q     = out_q;
    assign Q_VLD = out_vld_q;
  end else begin : g_nopipe
    assign Q     = rd_q;
    assign Q_VLD = rd_vld_q;
  end
endmodule

// File: tb/tb_ct_spsram_param.sv
`timescale 1ns/1ps
module tb_ct_spsram_param;
`ifdef CT_SPSRAM_INIT_CLR_EN
  localparam int INIT_CYC = 1024;
  localparam logic [127:0] EXP_RST_RD = '0;
`else
  localparam int INIT_CYC = 1;
  localparam logic [127:0] EXP_RST_RD = {16{8'h22}};
`endif

  logic         CLK, rst_n, CEN, GWEN;
  logic [9:0]   A;
  logic [127:0] D;
  logic [127:0] wen0;
  logic [15:0]  wen1;
  logic [7:0]   wen2;
  logic [127:0] Q0, Q1, Q2;
  logic         V0, V1, V2, I0, I1, I2;
  int n_cmp = 0, n_err = 0;

  // u0: 1-bit lanes, PIPE=0. u1: 8-bit lanes, PIPE=0. u2: 16-bit lanes, PIPE=1.
  ct_spsram_param u0 (.CLK(CLK), .cpurst_b(rst_n), .CEN(CEN), .GWEN(GWEN), .WEN(wen0),
                      .A(A), .D(D), .Q(Q0), .Q_VLD(V0), .INIT_DONE(I0));
  ct_spsram_param #(.WE_WIDTH(16)) u1 (.CLK(CLK), .cpurst_b(rst_n), .CEN(CEN), .GWEN(GWEN),
                      .WEN(wen1), .A(A), .D(D), .Q(Q1), .Q_VLD(V1), .INIT_DONE(I1));
  ct_spsram_param #(.WE_WIDTH(8), .PIPE(1)) u2 (.CLK(CLK), .cpurst_b(rst_n), .CEN(CEN),
                      .GWEN(GWEN), .WEN(wen2), .A(A), .D(D), .Q(Q2), .Q_VLD(V2),
                      .INIT_DONE(I2));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    CEN = 1'b1; GWEN = 1'b1; wen0 = '1; wen1 = '1; wen2 = '1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [127:0] d,
                    input logic [127:0] w0, input logic [15:0] w1, input logic [7:0] w2);
    CEN = 1'b0; GWEN = 1'b0; A = a; D = d; wen0 = w0; wen1 = w1; wen2 = w2;
    tick;
    idle;
  endtask

  task automatic rd(input logic [9:0] a);
    CEN = 1'b0; GWEN = 1'b1; A = a;
    tick;
    idle;
  endtask

  task automatic wait_init(input int start);
    int cyc;
    cyc = start;
    while (I0 !== 1'b1 && cyc < 3000) begin
      tick;
      cyc++;
    end
    chk("init_cycles", cyc, INIT_CYC);
    chk("init_u1", I1, 1'b1);
    chk("init_u2", I2, 1'b1);
  endtask

  initial begin
    logic [127:0] pat, w0m;
    pat = 128'h0123456789ABCDEF_FEDCBA9876543210;
    rst_n = 1'b0; idle; A = '0; D = '0;
    repeat (3) tick;
    chk("rst_q0", Q0, '0);
    chk("rst_vld0", V0, 1'b0);
    chk("rst_init", I0, 1'b0);
    chk("rst_q2", Q2, '0);
    rst_n = 1'b1;
`ifdef CT_SPSRAM_INIT_CLR_EN
    repeat (500) tick;
    chk("clr500_init", I0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst500_init", I0, 1'b0);
    chk("rst500_q", Q0, '0);
    tick;
    rst_n = 1'b1;
    repeat (99) tick;
    // write attempt during the clear must be ignored
    wr(10'd9, '1, '0, '0, '0);
    wait_init(100);
    rd(10'd0);    chk("clr_rd0", Q0, '0);  chk("clr_vld0", V0, 1'b1);
    rd(10'd511);  chk("clr_rd511", Q0, '0);
    rd(10'd1023); chk("clr_rd1023", Q0, '0);
    rd(10'd9);    chk("clr_rd9_ignored", Q0, '0);
    tick;         chk("clr_vld_drop", V0, 1'b0);
`else
    wait_init(0);
`endif
    // full write, then read on the next cycle
    wr(10'd3, {16{8'hA5}}, '0, '0, '0);
    rd(10'd3);
    chk("a5_q0", Q0, {16{8'hA5}}); chk("a5_vld0", V0, 1'b1);
    chk("a5_q1", Q1, {16{8'hA5}}); chk("a5_vld1", V1, 1'b1);
    chk("a5_vld2_early", V2, 1'b0); chk("a5_q2_early", Q2, '0);
    tick;
    chk("a5_vld0_drop", V0, 1'b0); chk("a5_q0_hold", Q0, {16{8'hA5}});
    chk("a5_q2", Q2, {16{8'hA5}}); chk("a5_vld2", V2, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("idle_q0", Q0, {16{8'hA5}});
      chk("idle_vld0", V0, 1'b0);
      chk("idle_vld2", V2, 1'b0);
    end
    // lane masking: only lane 0 written, then a no-op write
    w0m = {{127{1'b1}}, 1'b0};
    wr(10'd7, '0, '0, '0, '0);
    wr(10'd7, '1, w0m, 16'hFFFE, 8'hFE);
    wr(10'd7, '0, '1, '1, '1);
    rd(10'd7);
    chk("mask_q0", Q0, 128'h1);
    chk("mask_q1", Q1, 128'hFF);
    tick;
    chk("mask_q2", Q2, 128'hFFFF);
    // upper-half write on top of it
    wr(10'd7, pat, {64'h0, {64{1'b1}}}, 16'h00FF, 8'h0F);
    rd(10'd7);
    chk("half_q0", Q0, {64'h0123456789ABCDEF, 64'h1});
    chk("half_q1", Q1, {64'h0123456789ABCDEF, 64'hFF});
    tick;
    chk("half_q2", Q2, {64'h0123456789ABCDEF, 64'hFFFF});
    // back-to-back reads
    wr(10'd1, {16{8'h11}}, '0, '0, '0);
    wr(10'd2, {16{8'h22}}, '0, '0, '0);
    wr(10'd3, {16{8'h33}}, '0, '0, '0);
    CEN = 1'b0; GWEN = 1'b1; A = 10'd1;
    tick;
    chk("b2b_q0_1", Q0, {16{8'h11}}); chk("b2b_v0_1", V0, 1'b1); chk("b2b_v2_0", V2, 1'b0);
    A = 10'd2;
    tick;
    chk("b2b_q0_2", Q0, {16{8'h22}}); chk("b2b_v0_2", V0, 1'b1);
    chk("b2b_q2_1", Q2, {16{8'h11}}); chk("b2b_v2_1", V2, 1'b1);
    A = 10'd3;
    tick;
    chk("b2b_q0_3", Q0, {16{8'h33}}); chk("b2b_v0_3", V0, 1'b1);
    chk("b2b_q2_2", Q2, {16{8'h22}}); chk("b2b_v2_2", V2, 1'b1);
    idle;
    tick;
    chk("b2b_v0_end", V0, 1'b0);
    chk("b2b_q2_3", Q2, {16{8'h33}}); chk("b2b_v2_3", V2, 1'b1);
    tick;
    chk("b2b_v2_end", V2, 1'b0); chk("b2b_q2_hold", Q2, {16{8'h33}});
    // a write has no output effect
    wr(10'd4, '0, '0, '0, '0);
    chk("wr_q0_hold", Q0, {16{8'h33}}); chk("wr_vld0", V0, 1'b0);
    // reset during a pending PIPE=1 read, with a write held across reset
    CEN = 1'b0; GWEN = 1'b1; A = 10'd1;
    tick;
    rst_n = 1'b0; GWEN = 1'b0; A = 10'd2; D = '0; wen0 = '0; wen1 = '0; wen2 = '0;
    #1;
    chk("rstrd_q2", Q2, '0); chk("rstrd_v2", V2, 1'b0);
    chk("rstrd_q0", Q0, '0); chk("rstrd_init", I0, 1'b0);
    tick;
    tick;
    chk("rstrd_v2_dropped", V2, 1'b0);
    rst_n = 1'b1;
    tick;
    idle;
    wait_init(1);
    rd(10'd2);
    chk("rst_ignore_q0", Q0, EXP_RST_RD);
    chk("rst_ignore_v0", V0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
